// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the command, ALU and result signals of the ALU command sequencer.
// slave modport faces the sequencer, master modport faces producer/ALU/consumer.
// Signals: cmd_in/cmd_valid/cmd_ready (byte stream), alu_op/alu_a/alu_b/alu_res
// (ALU drive and result), res_out/res_err/res_valid/res_ready (result stream).
interface alu_cmd_sequencer_if;
  logic [7:0] cmd_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_res;
  logic [7:0] res_out;
  logic       res_err;
  logic       res_valid;
  logic       res_ready;

  modport slave (
    input  cmd_in, cmd_valid, alu_res, res_ready,
    output cmd_ready, alu_op, alu_a, alu_b, res_out, res_err, res_valid
  );

  modport master (
    output cmd_in, cmd_valid, alu_res, res_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, res_out, res_err, res_valid
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Purpose: two-byte command front-end driving a 4-bit ALU and returning its captured 8-bit result.
// Latency: byte 1 accepted at edge k, result captured and res_valid raised at edge k+EXEC_CYCLES.
// Backpressure: result held in RESP until res_ready; no command bytes accepted from byte 1 until release.
//
// Ports: clk (rising-edge clock), rst_n (synchronous active-low reset),
//   bus (alu_cmd_sequencer_if.slave): cmd_in/cmd_valid/cmd_ready command bytes,
//   alu_op/alu_a/alu_b registered ALU operands, alu_res combinational ALU result,
//   res_out/res_err/res_valid/res_ready captured result stream.
// Parameter EXEC_CYCLES (1..15): ALU settle cycles before capture.
// Optional macro ALU_SEQ_CHAIN_EN: byte-1 bit 7 substitutes the last good
//   result nibble for operand A.
module alu_cmd_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Counter value seen during the final settle cycle.
  localparam logic [3:0] LP_LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t     r_state;
  logic       r_cmd_ready;
  logic       r_res_valid;
  logic [7:0] r_res_out;
  logic       r_res_err;
  logic [3:0] r_alu_op;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [3:0] r_cnt;

  logic       w_cmd_fire;
  logic       w_capture;
  logic [7:0] w_cap_res;
  logic       w_cap_err;
  logic [3:0] w_a_byte1;

  assign w_cmd_fire = bus.cmd_valid && r_cmd_ready;
  assign w_capture  = (r_state == ST_EXEC) && (r_cnt == LP_LAST_CNT);

  // Error cases override the ALU output; unsupported opcodes win over divide-by-zero.
  always_comb begin
    w_cap_res = bus.alu_res;
    w_cap_err = 1'b0;
    if (r_alu_op >= 4'd13) begin
      w_cap_res = 8'h00;
      w_cap_err = 1'b1;
    end else if ((r_alu_op == 4'd3) && (r_alu_b == 4'h0)) begin
      w_cap_res = 8'hFF;
      w_cap_err = 1'b1;
    end
  end

`ifdef ALU_SEQ_CHAIN_EN
  logic [3:0] r_chain;

  // Operand A is swapped for the chained nibble when byte 1 asks for it.
  assign w_a_byte1 = bus.cmd_in[7] ? r_chain : r_alu_a;

  // Only error-free captures feed the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= 4'h0;
    end else if (w_capture && !w_cap_err) begin
      r_chain <= w_cap_res[3:0];
    end
  end
`else
  assign w_a_byte1 = r_alu_a;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_out   <= 8'h00;
      r_res_err   <= 1'b0;
      r_alu_op    <= 4'h0;
      r_alu_a     <= 4'h0;
      r_alu_b     <= 4'h0;
      r_cnt       <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Also covers the first cycle out of reset, when ready is still low.
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            r_alu_op <= bus.cmd_in[7:4];
            r_alu_a  <= bus.cmd_in[3:0];
            r_state  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (w_cmd_fire) begin
            r_alu_b     <= bus.cmd_in[3:0];
            r_alu_a     <= w_a_byte1;
            r_cnt       <= 4'h0;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_capture) begin
            r_res_out   <= w_cap_res;
            r_res_err   <= w_cap_err;
            r_res_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 4'h1;
          end
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.res_out   = r_res_out;
  assign bus.res_err   = r_res_err;
  assign bus.res_valid = r_res_valid;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: randomized commands with a queue-based reference
// model; a negedge monitor checks every result handshake, latency and hold rules.
// A second instance with EXEC_CYCLES=4 checks the capture instant.
module tb_alu_cmd_sequencer;
  localparam int E1 = 1;
  localparam int E4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if if_m ();
  alu_cmd_sequencer_if if_4 ();

  alu_cmd_sequencer #(.EXEC_CYCLES(E1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if_m.slave)
  );
  alu_cmd_sequencer #(.EXEC_CYCLES(E4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if_4.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU behaviour assumed by the bench.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'd0:    return 8'(a) + 8'(b);
      4'd1:    return 8'(a) - 8'(b);
      4'd2:    return 8'(a) * 8'(b);
      4'd3:    return (b != 4'h0) ? 8'(a / b) : 8'h00;
      4'd4:    return {4'h0, a & b};
      4'd5:    return {4'h0, a | b};
      4'd6:    return {4'h0, a ^ b};
      4'd7:    return {a, b};
      default: return {b, a};
    endcase
  endfunction

  assign if_m.alu_res = alu_fn(if_m.alu_op, if_m.alu_a, if_m.alu_b);

  bit   rr_hold = 1'b1;
  logic rr_val  = 1'b1;
  logic rr_rand = 1'b1;
  assign if_m.res_ready = rr_hold ? rr_val : rr_rand;

  initial forever begin
    @(posedge clk);
    #1;
    rr_rand = ($urandom_range(0, 3) != 0);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [7:0] res;
    logic       err;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_chain = 4'h0;

  // ---------------- monitor ----------------
  logic       p_valid, p_ready, p_err, p_cmd_rdy;
  logic [7:0] p_out;
  logic [3:0] p_op, p_a, p_b;
  bit         p_ok = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ok = 1'b0;
    end else begin
      if (p_ok) begin
        if (if_m.res_valid && !p_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_result actual=%0h required=none", if_m.res_out);
          end else begin
            chk("latency", 32'(cyc), 32'(exp_q[0].due));
          end
        end
        if (p_valid && !p_ready) begin
          chk("resp_hold_valid", 32'(if_m.res_valid), 32'd1);
          chk("resp_hold_out", {if_m.res_err, if_m.res_out}, {p_err, p_out});
        end
        if (!if_m.res_valid)
          chk("res_hold_idle", {if_m.res_err, if_m.res_out}, {p_err, p_out});
        if (!p_cmd_rdy && !if_m.cmd_ready)
          chk("alu_stable", {if_m.alu_op, if_m.alu_a, if_m.alu_b}, {p_op, p_a, p_b});
      end
      if (if_m.res_valid && if_m.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_handshake actual=%0h required=none", if_m.res_out);
        end else begin
          chk("res_out", if_m.res_out, exp_q[0].res);
          chk("res_err", if_m.res_err, exp_q[0].err);
          void'(exp_q.pop_front());
        end
      end
      p_valid   = if_m.res_valid;
      p_ready   = if_m.res_ready;
      p_out     = if_m.res_out;
      p_err     = if_m.res_err;
      p_cmd_rdy = if_m.cmd_ready;
      p_op      = if_m.alu_op;
      p_a       = if_m.alu_a;
      p_b       = if_m.alu_b;
      p_ok      = 1'b1;
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic send_byte(input logic [7:0] b, output int acc);
    int n = 0;
    acc = -1;
    if_m.cmd_in    = b;
    if_m.cmd_valid = 1'b1;
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (if_m.cmd_ready) acc = cyc + 1;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL cmd_accept timeout byte=%0h", b);
    end
    @(posedge clk);
    #1;
    if_m.cmd_valid = 1'b0;
    if_m.cmd_in    = 8'($urandom);
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input int gap);
    int a0, a1;
    logic [3:0] op, a, b;
    exp_t e;
    repeat (gap) begin @(posedge clk); #1; end
    send_byte(b0, a0);
    send_byte(b1, a1);
    op = b0[7:4];
    a  = b0[3:0];
    b  = b1[3:0];
`ifdef ALU_SEQ_CHAIN_EN
    if (b1[7]) a = m_chain;
`endif
    if (op >= 4'd13) begin
      e.res = 8'h00; e.err = 1'b1;
    end else if (op == 4'd3 && b == 4'h0) begin
      e.res = 8'hFF; e.err = 1'b1;
    end else begin
      e.res = alu_fn(op, a, b); e.err = 1'b0;
    end
`ifdef ALU_SEQ_CHAIN_EN
    if (!e.err) m_chain = e.res[3:0];
`endif
    e.due = a1 + E1;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_m.res_valid && n < 100);
    if (!if_m.res_valid) begin
      checks++; errors++;
      $display("FAIL %s res_valid timeout", name);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    exp_q.delete();
    m_chain = 4'h0;
    repeat (n) begin @(posedge clk); #1; end
    chk("rst_cmd_ready", 32'(if_m.cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(if_m.res_valid), 32'd0);
    chk("rst_res", {if_m.res_err, if_m.res_out}, 32'd0);
    chk("rst_alu", {if_m.alu_op, if_m.alu_a, if_m.alu_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", 32'(if_m.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rdy_after_rst", 32'(if_m.cmd_ready), 32'd1);
  endtask

  task automatic send_byte4(input logic [7:0] b, output int acc);
    int n = 0;
    acc = -1;
    if_4.cmd_in    = b;
    if_4.cmd_valid = 1'b1;
    while (acc < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (if_4.cmd_ready) acc = cyc + 1;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL cmd4_accept timeout byte=%0h", b);
    end
    @(posedge clk);
    #1;
    if_4.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1;
    int acc, seen;
    logic [3:0] op, b;
    if_m.cmd_in    = 8'h00;
    if_m.cmd_valid = 1'b0;
    if_4.cmd_in    = 8'h00;
    if_4.cmd_valid = 1'b0;
    if_4.alu_res   = 8'h00;
    if_4.res_ready = 1'b1;
    rr_hold = 1'b1;
    rr_val  = 1'b1;

    do_reset(3);

    // Add 5+3 with consumer always ready.
    send_cmd(8'h05, 8'h03, 0);
    wait_valid("add");
    chk("add_res", if_m.res_out, 8'h08);
    @(posedge clk); #1;
    drain();

    // Divide by zero, then unsupported opcode.
    send_cmd(8'h39, 8'h00, 0);
    wait_valid("div0");
    chk("div0_res", {if_m.res_err, if_m.res_out}, {1'b1, 8'hFF});
    @(posedge clk); #1;
    send_cmd(8'hE7, 8'h01, 1);
    wait_valid("badop");
    chk("badop_res", {if_m.res_err, if_m.res_out}, {1'b1, 8'h00});
    @(posedge clk); #1;
    drain();

    // Backpressure: multiply 7*3 held for 6 cycles.
    rr_val = 1'b0;
    send_cmd(8'h27, 8'h03, 0);
    wait_valid("bp");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", 32'(if_m.res_valid), 32'd1);
      chk("bp_out", if_m.res_out, 8'h15);
      chk("bp_cmd_ready", 32'(if_m.cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    rr_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", 32'(if_m.res_valid), 32'd0);
    chk("bp_release_ready", 32'(if_m.cmd_ready), 32'd1);
    @(posedge clk); #1;
    drain();

    // Chaining.
    send_cmd(8'h06, 8'h02, 0);
    send_cmd(8'h1F, 8'h81, 0);
    @(negedge clk);
`ifdef ALU_SEQ_CHAIN_EN
    chk("chain_alu_a", if_m.alu_a, 4'h8);
    wait_valid("chain");
    chk("chain_res", if_m.res_out, 8'h07);
`else
    chk("chain_alu_a", if_m.alu_a, 4'hF);
    wait_valid("chain");
    chk("chain_res", if_m.res_out, 8'h0E);
`endif
    @(posedge clk); #1;
    drain();

    // Pending result dropped by reset.
    rr_val = 1'b0;
    send_cmd(8'h27, 8'h03, 0);
    wait_valid("drop");
    @(posedge clk); #1;
    do_reset(2);
    rr_val = 1'b1;

    // Reset after byte 0 only, then a fresh command.
    send_byte(8'h1F, acc);
    do_reset(2);
    send_cmd(8'h0A, 8'h04, 0);
    wait_valid("post_rst");
    chk("post_rst_res", {if_m.res_err, if_m.res_out}, {1'b0, 8'h0E});
    @(posedge clk); #1;
    drain();

    // Capture instant with EXEC_CYCLES=4: ALU output changes every settle cycle.
    send_byte4(8'h05, acc);
    send_byte4(8'h03, acc);
    seen = -1;
    for (int i = 1; i <= 6; i++) begin
      if_4.alu_res = 8'hA0 + 8'(i);
      @(negedge clk);
      if (if_4.res_valid && seen < 0) seen = cyc;
      @(posedge clk); #1;
    end
    chk("exec4_latency", 32'(seen), 32'(acc + E4));
    chk("exec4_res", {if_4.res_err, if_4.res_out}, {1'b0, 8'hA4});

    // Randomized traffic with random consumer backpressure.
    rr_hold = 1'b0;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      b0 = {op, 4'($urandom_range(0, 15))};
      b1 = {1'($urandom), 3'($urandom), b};
      send_cmd(b0, b1, $urandom_range(0, 2));
    end
    drain();
    rr_hold = 1'b1;
    rr_val  = 1'b1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
